// File: rtl/mtrx_pkg.sv
// -----------------------------------------------------------------------------
// mtrx_pkg
// Shared definitions for the matrix engine, the matrix register file and the
// instruction decoder: operation encoding, engine FSM state encoding and the
// helpers that size the index counters and the MAC accumulator.
// No ports (package).
// -----------------------------------------------------------------------------
package mtrx_pkg;

    localparam logic [1:0] OP_MM  = 2'b00;
    localparam logic [1:0] OP_MS  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mtrx_state_e;

    // Bits needed for a row/column/k index counting 0..n-1.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // A dot product of n WIDTH x WIDTH products never exceeds 2*w+clog2(n) bits.
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    // Signed container able to hold any op result, including a negative SUB.
    function automatic int full_width(input int n, input int w);
        return acc_width(n, w) + 1;
    endfunction

endpackage

// File: rtl/mtrx_sat_trunc.sv
// -----------------------------------------------------------------------------
// mtrx_sat_trunc
// Reduces a full-width signed op result to a WIDTH-bit unsigned element.
// SATURATE=0 keeps the WIDTH LSBs (negative values wrap two's-complement);
// SATURATE=1 clamps to [0, 2**WIDTH-1].
// Ports:
//   value  in  IN_W   full-width signed result
//   result out WIDTH  element to store in the result matrix
// -----------------------------------------------------------------------------
module mtrx_sat_trunc #(
    parameter int WIDTH    = 8,
    parameter int IN_W     = 20,
    parameter int SATURATE = 0
) (
    input  logic signed [IN_W-1:0]  value,
    output logic        [WIDTH-1:0] result
);

    localparam logic signed [IN_W-1:0] MAX_VAL =
        $signed({{(IN_W-WIDTH){1'b0}}, {WIDTH{1'b1}}});

    always_comb begin
        result = value[WIDTH-1:0];
        if (SATURATE != 0) begin
            if (value < 0) begin
                result = '0;
            end else if (value > MAX_VAL) begin
                result = '1;
            end
        end
    end

endmodule

// File: rtl/mtrx_mac_engine.sv
// -----------------------------------------------------------------------------
// mtrx_mac_engine
// Sequential N x N matrix engine over WIDTH-bit unsigned elements. One
// multiply-accumulate (MM) or one element (MS/ADD/SUB) per RUN cycle.
// Operands are latched when start is accepted, so the caller may change its
// buses while the engine is busy.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   start   in   op request, sampled only in IDLE
//   op      in   2'b00 MM, 2'b01 MS, 2'b10 ADD, 2'b11 SUB
//   scalar  in   scalar operand for MS
//   a, b    in   operand matrices, row-major, element (r,c) at (r*N+c)*WIDTH
//   busy    out  high while RUN
//   done    out  one-cycle pulse, c complete
//   c       out  result matrix, held until the next accepted start
// -----------------------------------------------------------------------------
module mtrx_mac_engine
    import mtrx_pkg::*;
#(
    parameter int N        = 5,
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       scalar,
    input  logic [N*N*WIDTH-1:0]   a,
    input  logic [N*N*WIDTH-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [N*N*WIDTH-1:0]   c
);

    localparam int IDX_W  = idx_width(N);
    localparam int ACC_W  = acc_width(N, WIDTH);
    localparam int FULL_W = full_width(N, WIDTH);
    localparam int MAT_W  = N * N * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    mtrx_state_e state_q, state_d;

    logic [MAT_W-1:0]  a_q, b_q, c_q;
    logic [WIDTH-1:0]  scalar_q;
    logic [1:0]        op_q;
    logic [IDX_W-1:0]  row_q, col_q, k_q;
    logic [ACC_W-1:0]  acc_q;

    logic                     accept;
    logic                     elem_write;
    logic                     last_elem;
    int                       a_rk_base, b_kc_base, rc_base;
    logic [WIDTH-1:0]         a_rk, b_kc, a_rc, b_rc;
    logic [2*WIDTH-1:0]       mm_prod, ms_prod;
    logic [ACC_W-1:0]         mm_sum;
    logic [WIDTH:0]           add_sum, sub_diff;
    logic signed [FULL_W-1:0] full_val;
    logic [WIDTH-1:0]         elem_result;

    assign accept = (state_q == ST_IDLE) && start;

    // MM only completes an element when the dot product reaches its last term;
    // the element-wise ops complete one element every RUN cycle.
    assign elem_write = (op_q != OP_MM) || (k_q == LAST_IDX);
    assign last_elem  = elem_write && (row_q == LAST_IDX) && (col_q == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_elem) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand selection and full-width result for the element being produced.
    always_comb begin
        rc_base   = (int'(row_q) * N + int'(col_q)) * WIDTH;
        a_rk_base = (int'(row_q) * N + int'(k_q)) * WIDTH;
        b_kc_base = (int'(k_q) * N + int'(col_q)) * WIDTH;
        a_rk      = a_q[a_rk_base +: WIDTH];
        b_kc      = b_q[b_kc_base +: WIDTH];
        a_rc      = a_q[rc_base +: WIDTH];
        b_rc      = b_q[rc_base +: WIDTH];
        mm_prod   = {{WIDTH{1'b0}}, a_rk} * {{WIDTH{1'b0}}, b_kc};
        ms_prod   = {{WIDTH{1'b0}}, a_rc} * {{WIDTH{1'b0}}, scalar_q};
        mm_sum    = acc_q + {{(ACC_W-2*WIDTH){1'b0}}, mm_prod};
        add_sum   = {1'b0, a_rc} + {1'b0, b_rc};
        sub_diff  = {1'b0, a_rc} - {1'b0, b_rc};
        full_val  = '0;
        case (op_q)
            OP_MM:   full_val = $signed({1'b0, mm_sum});
            OP_MS:   full_val = $signed({{(FULL_W-2*WIDTH){1'b0}}, ms_prod});
            OP_ADD:  full_val = $signed({{(FULL_W-WIDTH-1){1'b0}}, add_sum});
            OP_SUB:  full_val = $signed({{(FULL_W-WIDTH-1){sub_diff[WIDTH]}}, sub_diff});
            default: full_val = '0;
        endcase
    end

    mtrx_sat_trunc #(
        .WIDTH    (WIDTH),
        .IN_W     (FULL_W),
        .SATURATE (SATURATE)
    ) u_sat_trunc (
        .value  (full_val),
        .result (elem_result)
    );

    // Operand latches, counters, accumulator and result matrix. Accepting a
    // start clears the previous result so unwritten elements read 0 in RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            scalar_q <= '0;
            op_q     <= OP_MM;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            c_q      <= '0;
            scalar_q <= scalar;
            op_q     <= op;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
        end else if (state_q == ST_RUN) begin
            if (elem_write) begin
                c_q[rc_base +: WIDTH] <= elem_result;
                acc_q <= '0;
                k_q   <= '0;
                if (col_q == LAST_IDX) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else begin
                acc_q <= mm_sum;
                k_q   <= k_q + 1'b1;
            end
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_mtrx_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_mtrx_mac_engine
// Scoreboard bench: three engines (N=5/WIDTH=8 wrap, N=5/WIDTH=8 saturate,
// N=3/WIDTH=16 wrap). Expected matrices are pushed when an op is started and
// popped when the matching engine raises done.
// -----------------------------------------------------------------------------
module tb_mtrx_mac_engine;
    import mtrx_pkg::*;

    localparam int N   = 5;
    localparam int W   = 8;
    localparam int MW  = N * N * W;
    localparam int N3  = 3;
    localparam int W3  = 16;
    localparam int MW3 = N3 * N3 * W3;
    localparam int LAT_MM = N * N * N + 1;
    localparam int LAT_EW = N * N + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic            start  = 1'b0;
    logic [1:0]      op     = OP_MM;
    logic [W-1:0]    scalar = '0;
    logic [MW-1:0]   a      = '0;
    logic [MW-1:0]   b      = '0;
    logic            busy, done, busy_s, done_s;
    logic [MW-1:0]   c, c_s;

    logic            start3  = 1'b0;
    logic [1:0]      op3     = OP_MM;
    logic [W3-1:0]   scalar3 = '0;
    logic [MW3-1:0]  a3      = '0;
    logic [MW3-1:0]  b3      = '0;
    logic            busy3, done3;
    logic [MW3-1:0]  c3;

    int cyc = 0;
    int err_cnt = 0;
    int chk_cnt = 0;

    logic [MW-1:0]  exp_q[$];
    logic [MW-1:0]  exp_s_q[$];
    logic [MW3-1:0] exp3_q[$];

    mtrx_mac_engine #(.N(N), .WIDTH(W), .SATURATE(0)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .scalar(scalar),
        .a(a), .b(b), .busy(busy), .done(done), .c(c)
    );

    mtrx_mac_engine #(.N(N), .WIDTH(W), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .op(op), .scalar(scalar),
        .a(a), .b(b), .busy(busy_s), .done(done_s), .c(c_s)
    );

    mtrx_mac_engine #(.N(N3), .WIDTH(W3), .SATURATE(0)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .op(op3), .scalar(scalar3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .c(c3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        chk_cnt++;
        if (observed !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Reference result for the 5x5 / 8-bit engines, straight from the op definitions.
    function automatic logic [MW-1:0] model(input logic [1:0] m_op, input logic [MW-1:0] m_a,
                                            input logic [MW-1:0] m_b, input logic [W-1:0] m_s,
                                            input bit sat);
        logic [MW-1:0] res;
        longint v, ea, eb;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int cc = 0; cc < N; cc++) begin
                ea = longint'(m_a[(r*N+cc)*W +: W]);
                eb = longint'(m_b[(r*N+cc)*W +: W]);
                case (m_op)
                    OP_MM: begin
                        v = 0;
                        for (int k = 0; k < N; k++)
                            v += longint'(m_a[(r*N+k)*W +: W]) * longint'(m_b[(k*N+cc)*W +: W]);
                    end
                    OP_MS:   v = ea * longint'(m_s);
                    OP_ADD:  v = ea + eb;
                    default: v = ea - eb;
                endcase
                if (sat) begin
                    if (v < 0) v = 0;
                    else if (v > 255) v = 255;
                end
                res[(r*N+cc)*W +: W] = v[W-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [MW-1:0] checker_mat(input logic [W-1:0] p, input logic [W-1:0] q);
        logic [MW-1:0] m;
        for (int r = 0; r < N; r++)
            for (int cc = 0; cc < N; cc++)
                m[(r*N+cc)*W +: W] = ((r + cc) % 2 == 0) ? p : q;
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < N * N; i++) m[i*W +: W] = W'($urandom_range(0, 255));
        return m;
    endfunction

    // Scoreboard: every done pops the oldest expected result of that engine.
    always @(negedge clock) begin
        if (reset && done) begin
            if (exp_q.size() == 0) checkOutput("done_unexpected", 1, 0);
            else checkOutput("c_wrap", c, exp_q.pop_front());
        end
        if (reset && done_s) begin
            if (exp_s_q.size() == 0) checkOutput("done_s_unexpected", 1, 0);
            else checkOutput("c_sat", c_s, exp_s_q.pop_front());
        end
        if (reset && done3) begin
            if (exp3_q.size() == 0) checkOutput("done3_unexpected", 1, 0);
            else checkOutput("c_n3", c3, exp3_q.pop_front());
        end
    end

    // Starts one op on the two 5x5 engines, then tracks latency and busy length.
    // With disturb set, a stray start and new a/b values are driven mid-RUN.
    task automatic applyStimulus(input logic [1:0] t_op, input logic [MW-1:0] t_a,
                                 input logic [MW-1:0] t_b, input logic [W-1:0] t_s,
                                 input bit disturb);
        int  t0, busy_cnt, exp_lat;
        bit  seen;
        exp_lat = (t_op == OP_MM) ? LAT_MM : LAT_EW;
        @(posedge clock); #1;
        op = t_op; a = t_a; b = t_b; scalar = t_s; start = 1'b1;
        t0 = cyc;
        exp_q.push_back(model(t_op, t_a, t_b, t_s, 1'b0));
        exp_s_q.push_back(model(t_op, t_a, t_b, t_s, 1'b1));
        @(posedge clock); #1;
        start = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (disturb && i == 10) begin
                start = 1'b1; op = OP_ADD; a = rand_mat(); b = rand_mat(); scalar = 8'd7;
            end
            if (disturb && i == 11) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                checkOutput("latency", cyc - t0, exp_lat);
                checkOutput("busy_in_done", busy, 0);
            end else if (busy) begin
                busy_cnt++;
            end
        end
        if (!seen) checkOutput("done_timeout", 0, 1);
        checkOutput("busy_cycles", busy_cnt, exp_lat - 1);
    endtask

    logic [MW3-1:0] ident3, bm1, bm2;
    int  t0_3, d1, d2;
    bit  seen3, seen_bad;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_c", c, 0);
        checkOutput("rst_c_sat", c_s, 0);
        checkOutput("rst_busy3", busy3, 0);
        checkOutput("rst_c3", c3, 0);
        @(posedge clock); #1 reset = 1'b1;

        // Checkerboard A times all-ones B, then the same A times scalar 2
        applyStimulus(OP_MM, checker_mat(8'd1, 8'd2), checker_mat(8'd1, 8'd1), 8'd0, 1'b0);
        applyStimulus(OP_MS, checker_mat(8'd1, 8'd2), '0, 8'd2, 1'b0);
        // Overflowing MM: 5*16*16 = 1280
        applyStimulus(OP_MM, checker_mat(8'd16, 8'd16), checker_mat(8'd16, 8'd16), 8'd0, 1'b0);
        // ADD overflow, SUB mixed sign
        applyStimulus(OP_ADD, checker_mat(8'd200, 8'd200), checker_mat(8'd100, 8'd100), 8'd0, 1'b0);
        applyStimulus(OP_SUB, checker_mat(8'd10, 8'd20), checker_mat(8'd20, 8'd10), 8'd0, 1'b0);
        // Random ops
        for (int i = 0; i < 4; i++)
            applyStimulus(2'($urandom_range(0, 3)), rand_mat(), rand_mat(), 8'($urandom_range(0, 255)), 1'b0);

        // Reset in RUN cycle 40 discards the op
        @(posedge clock); #1;
        op = OP_MM; a = checker_mat(8'd1, 8'd1); b = checker_mat(8'd1, 8'd1); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (39) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_c", c, 0);
        checkOutput("midrst_c_sat", c_s, 0);
        @(posedge clock); #1 reset = 1'b1;
        seen_bad = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (done || done_s || busy) seen_bad = 1'b1;
        end
        checkOutput("no_done_after_rst", seen_bad, 0);

        // Restart MM of ones with a stray start and new operands mid-RUN
        applyStimulus(OP_MM, checker_mat(8'd1, 8'd1), checker_mat(8'd1, 8'd1), 8'd0, 1'b1);
        seen_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (busy || done) seen_bad = 1'b1;
        end
        checkOutput("stray_start_ignored", seen_bad, 0);

        // N=3, WIDTH=16: identity * B, back-to-back with start held high
        ident3 = '0;
        for (int i = 0; i < N3; i++) ident3[(i*N3+i)*W3 +: W3] = 16'd1;
        for (int i = 0; i < N3 * N3; i++) begin
            bm1[i*W3 +: W3] = W3'($urandom_range(0, 65535));
            bm2[i*W3 +: W3] = W3'($urandom_range(0, 65535));
        end
        @(posedge clock); #1;
        op3 = OP_MM; a3 = ident3; b3 = bm1; start3 = 1'b1;
        t0_3 = cyc;
        exp3_q.push_back(bm1);
        exp3_q.push_back(bm2);
        @(posedge clock); #1;
        b3 = bm2;
        seen3 = 1'b0;
        d1 = 0;
        for (int i = 0; i < 100 && !seen3; i++) begin
            @(negedge clock);
            if (done3) begin seen3 = 1'b1; d1 = cyc; end
        end
        if (!seen3) checkOutput("done3_timeout", 0, 1);
        checkOutput("latency_n3", d1 - t0_3, N3 * N3 * N3 + 1);
        @(posedge clock);
        @(posedge clock); #1;
        start3 = 1'b0;
        seen3 = 1'b0;
        d2 = 0;
        for (int i = 0; i < 100 && !seen3; i++) begin
            @(negedge clock);
            if (done3) begin seen3 = 1'b1; d2 = cyc; end
        end
        if (!seen3) checkOutput("done3_b2b_timeout", 0, 1);
        checkOutput("b2b_spacing_n3", d2 - d1, N3 * N3 * N3 + 2);

        repeat (5) @(negedge clock);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("queue_s_empty", exp_s_q.size(), 0);
        checkOutput("queue3_empty", exp3_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
